// File: rtl/ex_stage_mdu.sv
// Execute stage: forwarding network, single-cycle ALU, iterative RV32M
// multiply/divide unit and the EX/MEM output register with valid/ready handshake.
module ex_stage_mdu #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int NFWD   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [3:0]              alu_op,
    input  logic                    alu_src,
    input  logic                    mdu_en,
    input  logic [2:0]              mdu_op,
    input  logic [REG_W-1:0]        rs1,
    input  logic [REG_W-1:0]        rs2,
    input  logic [REG_W-1:0]        rd,
    input  logic [DATA_W-1:0]       reg_data1,
    input  logic [DATA_W-1:0]       reg_data2,
    input  logic [DATA_W-1:0]       imm,
    input  logic [NFWD-1:0]         fwd_we,
    input  logic [NFWD*REG_W-1:0]   fwd_rd,
    input  logic [NFWD*DATA_W-1:0]  fwd_data,
    input  logic                    flush,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_result,
    output logic [DATA_W-1:0]       out_store_data,
    output logic [REG_W-1:0]        out_rd,
    output logic                    stall_req
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int SH_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    // ALU opcode encoding
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    // RV32M funct3 values that need individual decoding
    localparam logic [2:0] MDU_MUL   = 3'b000;
    localparam logic [2:0] MDU_MULHU = 3'b011;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          op_q;
    logic                neg_q;
    logic [DATA_W-1:0]   mcand_q;     // multiplicand magnitude or divisor magnitude
    logic [DATA_W-1:0]   acc_q;       // product high half or partial remainder
    logic [DATA_W-1:0]   lo_q;        // multiplier / product low half or dividend / quotient
    logic [REG_W-1:0]    pend_rd_q;
    logic [DATA_W-1:0]   pend_store_q;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_result_q;
    logic [DATA_W-1:0]   out_store_q;
    logic [REG_W-1:0]    out_rd_q;

    logic [DATA_W-1:0]   opa_fwd, opb_fwd, alu_b, alu_res;
    logic                accept;
    logic                a_signed, b_signed, a_neg, b_neg, neg_d;
    logic [DATA_W-1:0]   a_mag, b_mag, mcand_d, lo_d;
    logic [DATA_W:0]     mul_sum, div_shift, div_diff;
    logic                div_ok;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix, rem_fix, mdu_res;

    function automatic logic [DATA_W-1:0] alu(input logic [3:0] op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        logic [SH_W-1:0]   sh;
        logic [DATA_W-1:0] r;
        sh = b[SH_W-1:0];
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLL:  r = a << sh;
            ALU_SLT:  r = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: r = {{(DATA_W-1){1'b0}}, a < b};
            ALU_XOR:  r = a ^ b;
            ALU_SRL:  r = a >> sh;
            ALU_SRA:  r = $unsigned($signed(a) >>> sh);
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            ALU_PASS: r = b;
            default:  r = '0;
        endcase
        return r;
    endfunction

    // Operand forwarding: the youngest matching source wins, x0 is never forwarded
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        opa_fwd = reg_data1;
        opb_fwd = reg_data2;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_we[i] && fwd_rd[i*REG_W +: REG_W] == rs1 && rs1 != '0)
                opa_fwd = fwd_data[i*DATA_W +: DATA_W];
            if (fwd_we[i] && fwd_rd[i*REG_W +: REG_W] == rs2 && rs2 != '0)
                opb_fwd = fwd_data[i*DATA_W +: DATA_W];
        end
    end

    assign alu_b     = alu_src ? imm : opb_fwd;
    assign alu_res   = alu(alu_op, opa_fwd, alu_b);
    assign stall_req = (state_q != IDLE) || (out_valid_q && !out_ready);
    assign accept    = in_valid && (state_q == IDLE) && !flush && (!out_valid_q || out_ready);

    // MDU operand setup: convert to magnitudes and remember the final sign fix
    always_comb begin
        a_signed = mdu_op[2] ? !mdu_op[0] : (mdu_op != MDU_MULHU);
        b_signed = mdu_op[2] ? !mdu_op[0] : !mdu_op[1];
        a_neg    = a_signed && opa_fwd[DATA_W-1];
        b_neg    = b_signed && opb_fwd[DATA_W-1];
        a_mag    = a_neg ? -opa_fwd : opa_fwd;
        b_mag    = b_neg ? -opb_fwd : opb_fwd;
        if (!mdu_op[2]) begin
            neg_d   = a_neg ^ b_neg;
            mcand_d = a_mag;
            lo_d    = b_mag;
        end else begin
            // divide by zero keeps the all-ones quotient unsigned; remainder follows the dividend
            neg_d   = mdu_op[1] ? a_neg : ((a_neg ^ b_neg) && (opb_fwd != '0));
            mcand_d = b_mag;
            lo_d    = a_mag;
        end
    end

    // One shift-add or restoring-subtract step, plus final result selection
    always_comb begin
        mul_sum   = {1'b0, acc_q} + {1'b0, (lo_q[0] ? mcand_q : '0)};
        div_shift = {acc_q, lo_q[DATA_W-1]};
        div_diff  = div_shift - {1'b0, mcand_q};
        div_ok    = !div_diff[DATA_W];
        prod_fix  = neg_q ? -{acc_q, lo_q} : {acc_q, lo_q};
        quo_fix   = neg_q ? -lo_q : lo_q;
        rem_fix   = neg_q ? -acc_q : acc_q;
        if (op_q[2])
            mdu_res = op_q[1] ? rem_fix : quo_fix;
        else if (op_q == MDU_MUL)
            mdu_res = prod_fix[DATA_W-1:0];
        else
            mdu_res = prod_fix[2*DATA_W-1:DATA_W];
    end

    // MDU FSM, iteration datapath and EX/MEM output register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the datapath registers are reset too; they are few and it keeps outputs deterministic.
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            neg_q        <= 1'b0;
            mcand_q      <= '0;
            acc_q        <= '0;
            lo_q         <= '0;
            pend_rd_q    <= '0;
            pend_store_q <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_store_q  <= '0;
            out_rd_q     <= '0;
        end else if (flush) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept && !mdu_en) begin
                out_valid_q  <= 1'b1;
                out_result_q <= alu_res;
                out_store_q  <= opb_fwd;
                out_rd_q     <= rd;
            end else if (state_q == DONE) begin
                out_valid_q  <= 1'b1;
                out_result_q <= mdu_res;
                out_store_q  <= pend_store_q;
                out_rd_q     <= pend_rd_q;
            end else if (out_valid_q && out_ready) begin
                out_valid_q  <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (accept && mdu_en) begin
                        state_q      <= BUSY;
                        cnt_q        <= '0;
                        op_q         <= mdu_op;
                        neg_q        <= neg_d;
                        mcand_q      <= mcand_d;
                        acc_q        <= '0;
                        lo_q         <= lo_d;
                        pend_rd_q    <= rd;
                        pend_store_q <= opb_fwd;
                    end
                end
                BUSY: begin
                    if (op_q[2]) begin
                        acc_q <= div_ok ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
                        lo_q  <= {lo_q[DATA_W-2:0], div_ok};
                    end else begin
                        acc_q <= mul_sum[DATA_W:1];
                        lo_q  <= {mul_sum[0], lo_q[DATA_W-1:1]};
                    end
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST)
                        state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid      = out_valid_q;
    assign out_result     = out_result_q;
    assign out_store_data = out_store_q;
    assign out_rd         = out_rd_q;

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Scoreboard bench for ex_stage_mdu: stimulus pushes expected results,
// a monitor pops and compares on every output handshake.
module tb_ex_stage_mdu;

    localparam logic [3:0] ADD = 4'd0;
    localparam logic [3:0] SUB = 4'd1;
    localparam logic [3:0] SLT = 4'd3;
    localparam logic [3:0] XOR = 4'd5;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, alu_src, mdu_en, flush, out_ready;
    logic [3:0]  alu_op;
    logic [2:0]  mdu_op;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] reg_data1, reg_data2, imm;
    logic [1:0]  fwd_we;
    logic [9:0]  fwd_rd;
    logic [63:0] fwd_data;
    logic        out_valid, stall_req;
    logic [31:0] out_result, out_store_data;
    logic [4:0]  out_rd;

    typedef struct {
        logic [31:0] res;
        logic [31:0] st;
        logic [4:0]  rd;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    ex_stage_mdu #(.DATA_W(32), .REG_W(5), .NFWD(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_op(alu_op), .alu_src(alu_src),
        .mdu_en(mdu_en), .mdu_op(mdu_op), .rs1(rs1), .rs2(rs2), .rd(rd),
        .reg_data1(reg_data1), .reg_data2(reg_data2), .imm(imm),
        .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .flush(flush),
        .out_ready(out_ready), .out_valid(out_valid), .out_result(out_result),
        .out_store_data(out_store_data), .out_rd(out_rd), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every transferred output must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                check("unexpected output", {31'b0, out_valid}, 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb result", out_result, e.res);
                check("sb store", out_store_data, e.st);
                check("sb rd", 32'(out_rd), 32'(e.rd));
            end
        end
    end

    task automatic set_fwd(input logic [1:0] we, input logic [4:0] rd0, input logic [31:0] d0,
                           input logic [4:0] rd1, input logic [31:0] d1);
        fwd_we   = we;
        fwd_rd   = {rd1, rd0};
        fwd_data = {d1, d0};
    endtask

    // Present one instruction, wait for acceptance, push its expectation if it will complete
    task automatic send(input logic mdu, input logic [3:0] aop, input logic [2:0] mop,
                        input logic src, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rdd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] im, input logic push,
                        input logic [31:0] exp_res, input logic [31:0] exp_st,
                        output int waits);
        logic ok;
        exp_t e;
        mdu_en = mdu; alu_op = aop; mdu_op = mop; alu_src = src;
        rs1 = r1; rs2 = r2; rd = rdd; reg_data1 = d1; reg_data2 = d2; imm = im;
        in_valid = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            ok = !stall_req;
            @(posedge clk);
            #1;
            if (ok) break;
            waits++;
            if (waits >= 200) begin
                check("accept within budget", {31'b0, ok}, 32'h1);
                break;
            end
        end
        in_valid = 1'b0;
        if (push) begin
            e.res = exp_res; e.st = exp_st; e.rd = rdd;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, lat;
        logic all_stall, seen;

        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        alu_op = ADD; alu_src = 1'b0; mdu_en = 1'b0; mdu_op = MUL;
        rs1 = '0; rs2 = '0; rd = '0; reg_data1 = '0; reg_data2 = '0; imm = '0;
        set_fwd(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);

        // Reset state
        #2;
        check("reset out_valid", {31'b0, out_valid}, 32'h0);
        check("reset out_result", out_result, 32'h0);
        check("reset out_store", out_store_data, 32'h0);
        check("reset out_rd", 32'(out_rd), 32'h0);
        check("reset stall", {31'b0, stall_req}, 32'h0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Forward priority: fwd0 beats fwd1; rs2 falls back to register data
        set_fwd(2'b11, 5'd5, 32'h11, 5'd5, 32'h22);
        send(1'b0, ADD, MUL, 1'b1, 5'd5, 5'd3, 5'd10, 32'h99, 32'h33, 32'h1, 1'b1, 32'h12, 32'h33, w);
        check("alu one-edge valid", {31'b0, out_valid}, 32'h1);
        check("alu one-edge result", out_result, 32'h12);
        // Only fwd1 active, and rs2 forwarded as store data; back-to-back accept
        set_fwd(2'b10, 5'd5, 32'h11, 5'd5, 32'h22);
        send(1'b0, ADD, MUL, 1'b1, 5'd5, 5'd5, 5'd11, 32'h99, 32'h33, 32'h1, 1'b1, 32'h23, 32'h22, w);
        check("back-to-back waits", 32'(w), 32'h0);
        // x0 guard
        set_fwd(2'b01, 5'd0, 32'hFF, 5'd0, 32'h0);
        send(1'b0, ADD, MUL, 1'b1, 5'd0, 5'd0, 5'd12, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, w);
        set_fwd(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        // A few more ALU patterns with register operands
        send(1'b0, SUB, MUL, 1'b0, 5'd1, 5'd2, 5'd13, 32'd10, 32'd3, 32'h0, 1'b1, 32'd7, 32'd3, w);
        send(1'b0, XOR, MUL, 1'b0, 5'd1, 5'd2, 5'd14, 32'hF0, 32'h3C, 32'h0, 1'b1, 32'hCC, 32'h3C, w);
        send(1'b0, SLT, MUL, 1'b0, 5'd1, 5'd2, 5'd15, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b1, 32'd1, 32'd1, w);

        // Multiply with latency and stall observation on the first op
        send(1'b1, ADD, MUL, 1'b0, 5'd1, 5'd2, 5'd16, 32'hFFFFFFFF, 32'd2, 32'h0, 1'b1, 32'hFFFFFFFE, 32'd2, w);
        lat = 0;
        all_stall = stall_req;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = n;
                break;
            end
            if (!stall_req) all_stall = 1'b0;
        end
        check("mul latency", 32'(lat), 32'd33);
        check("stall during mul", {31'b0, all_stall}, 32'h1);
        send(1'b1, ADD, MULH,   1'b0, 5'd1, 5'd2, 5'd17, 32'hFFFFFFFF, 32'd2, 32'h0, 1'b1, 32'hFFFFFFFF, 32'd2, w);
        send(1'b1, ADD, MULHU,  1'b0, 5'd1, 5'd2, 5'd18, 32'hFFFFFFFF, 32'd2, 32'h0, 1'b1, 32'h00000001, 32'd2, w);
        send(1'b1, ADD, MULHSU, 1'b0, 5'd1, 5'd2, 5'd19, 32'hFFFFFFFF, 32'd2, 32'h0, 1'b1, 32'hFFFFFFFF, 32'd2, w);

        // Divide, including divide-by-zero and signed overflow
        send(1'b1, ADD, DIV,  1'b0, 5'd1, 5'd2, 5'd20, 32'd7, 32'd0, 32'h0, 1'b1, 32'hFFFFFFFF, 32'd0, w);
        send(1'b1, ADD, REM,  1'b0, 5'd1, 5'd2, 5'd21, 32'd7, 32'd0, 32'h0, 1'b1, 32'd7, 32'd0, w);
        send(1'b1, ADD, DIV,  1'b0, 5'd1, 5'd2, 5'd22, 32'hFFFFFFF9, 32'd0, 32'h0, 1'b1, 32'hFFFFFFFF, 32'd0, w);
        send(1'b1, ADD, REM,  1'b0, 5'd1, 5'd2, 5'd23, 32'hFFFFFFF9, 32'd0, 32'h0, 1'b1, 32'hFFFFFFF9, 32'd0, w);
        send(1'b1, ADD, DIV,  1'b0, 5'd1, 5'd2, 5'd24, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h80000000, 32'hFFFFFFFF, w);
        send(1'b1, ADD, REM,  1'b0, 5'd1, 5'd2, 5'd25, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0, 32'hFFFFFFFF, w);
        send(1'b1, ADD, DIV,  1'b0, 5'd1, 5'd2, 5'd26, 32'hFFFFFFF9, 32'd2, 32'h0, 1'b1, 32'hFFFFFFFD, 32'd2, w);
        send(1'b1, ADD, REM,  1'b0, 5'd1, 5'd2, 5'd27, 32'hFFFFFFF9, 32'd2, 32'h0, 1'b1, 32'hFFFFFFFF, 32'd2, w);
        send(1'b1, ADD, DIVU, 1'b0, 5'd1, 5'd2, 5'd28, 32'd100, 32'd7, 32'h0, 1'b1, 32'd14, 32'd7, w);
        send(1'b1, ADD, REMU, 1'b0, 5'd1, 5'd2, 5'd29, 32'd100, 32'd7, 32'h0, 1'b1, 32'd2, 32'd7, w);

        // Back-pressure: result held 3 cycles while the next op waits
        send(1'b0, ADD, MUL, 1'b1, 5'd1, 5'd0, 5'd7, 32'h100, 32'h0, 32'h23, 1'b1, 32'h123, 32'h0, w);
        out_ready = 1'b0;
        mdu_en = 1'b0; alu_op = ADD; alu_src = 1'b1; rs1 = 5'd1; rd = 5'd8;
        reg_data1 = 32'h200; imm = 32'h1; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp valid held", {31'b0, out_valid}, 32'h1);
            check("bp result frozen", out_result, 32'h123);
            check("bp rd frozen", 32'(out_rd), 32'd7);
            check("bp stall", {31'b0, stall_req}, 32'h1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(1'b0, ADD, MUL, 1'b1, 5'd1, 5'd0, 5'd8, 32'h200, 32'h0, 32'h1, 1'b1, 32'h201, 32'h0, w);
        check("bp release accept", 32'(w), 32'h0);

        // Flush in the middle of a multiply
        send(1'b1, ADD, MUL, 1'b0, 5'd1, 5'd2, 5'd30, 32'd3, 32'd5, 32'h0, 1'b0, 32'h0, 32'h0, w);
        repeat (9) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush stall low", {31'b0, stall_req}, 32'h0);
        check("flush valid low", {31'b0, out_valid}, 32'h0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("flushed op never completes", {31'b0, seen}, 32'h0);
        send(1'b0, ADD, MUL, 1'b1, 5'd1, 5'd0, 5'd9, 32'h40, 32'h0, 32'h2, 1'b1, 32'h42, 32'h0, w);

        // Asynchronous reset in the middle of a multiply
        send(1'b1, ADD, MUL, 1'b0, 5'd1, 5'd2, 5'd31, 32'd3, 32'd5, 32'h0, 1'b0, 32'h0, 32'h0, w);
        repeat (5) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        check("async rst valid", {31'b0, out_valid}, 32'h0);
        check("async rst result", out_result, 32'h0);
        check("async rst store", out_store_data, 32'h0);
        check("async rst rd", 32'(out_rd), 32'h0);
        check("async rst stall", {31'b0, stall_req}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(1'b0, ADD, MUL, 1'b1, 5'd1, 5'd0, 5'd4, 32'd5, 32'h0, 32'd5, 1'b1, 32'd10, 32'h0, w);

        // Drain the scoreboard
        for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
            @(posedge clk); #1;
        end
        check("scoreboard drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
